// File: rtl/lpc_reg_seq.sv
// Fill/serve sequencer for the LPC coefficient bank: streams NREG words in, then serves indexed reads.
// Owns the bank's one-hot write and read selects.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FILL  | accepting producer words into entries 0..NREG-1 in order
//   SERVE | bank complete; producer stalled; consumer reads until release
//
// "release" is a reserved word in SystemVerilog, so the consumer release input is named release_req.
module lpc_reg_seq #(
   parameter int NREG = 9,
   parameter int DW   = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   input  logic            rd_req,
   input  logic [3:0]      rd_idx,
   output logic            rd_valid,
   output logic [DW-1:0]   rd_data,
   output logic            rd_err,
   input  logic            release_req,
   output logic            full,
   output logic [3:0]      wcnt,
   output logic [NREG-1:0] bank_wsel,
   output logic [DW-1:0]   bank_wdata,
   output logic [NREG-1:0] bank_rsel,
   input  logic [DW-1:0]   bank_rdata
);

   typedef enum logic {
      FILL  = 1'b0,
      SERVE = 1'b1
   } state_t;

   localparam logic [3:0]      LAST_IDX = 4'(NREG - 1);
   localparam logic [3:0]      NREG_CNT = 4'(NREG);
   localparam logic [NREG-1:0] SEL_ONE  = NREG'(1);

   state_t     state, state_nxt;
   logic [3:0] wcnt_nxt;
   logic       idx_ok;
   logic       rd_ok;
   logic       rd_bad;

   assign idx_ok     = (rd_idx < NREG_CNT);
   assign full       = (state == SERVE);
   assign bank_wdata = in_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FILL;
         wcnt  <= 4'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      in_ready  = 1'b0;
      bank_wsel = '0;
      bank_rsel = '0;
      rd_ok     = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               bank_wsel = SEL_ONE << wcnt;
               wcnt_nxt  = wcnt + 4'd1;
               if (wcnt == LAST_IDX) state_nxt = SERVE;
            end
         end
         SERVE: begin
            if (rd_req && idx_ok) begin
               rd_ok     = 1'b1;
               bank_rsel = SEL_ONE << rd_idx;
            end
            // A read issued alongside release is still served; the bank is untouched by the transition.
            if (release_req) begin
               state_nxt = FILL;
               wcnt_nxt  = 4'd0;
            end
         end
         default: begin
            state_nxt = FILL;
            wcnt_nxt  = 4'd0;
         end
      endcase
      rd_bad = rd_req && !rd_ok;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_ok;
         rd_err   <= rd_bad;
         if (rd_ok) rd_data <= bank_rdata;
      end
   end

endmodule

// File: tb/tb_lpc_reg_seq.sv
// Directed bench for lpc_reg_seq: vector table for fill/serve basics plus hand sequences for gaps,
// refill and mid-fill reset. A behavioural bank model sits on the select/data ports.
module tb_lpc_reg_seq;

   localparam int NREG = 9;
   localparam int DW   = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            rd_req;
   logic [3:0]      rd_idx;
   logic            rd_valid;
   logic [DW-1:0]   rd_data;
   logic            rd_err;
   logic            release_req;
   logic            full;
   logic [3:0]      wcnt;
   logic [NREG-1:0] bank_wsel;
   logic [DW-1:0]   bank_wdata;
   logic [NREG-1:0] bank_rsel;
   logic [DW-1:0]   bank_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lpc_reg_seq #(.NREG(NREG), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
      .release_req(release_req), .full(full), .wcnt(wcnt),
      .bank_wsel(bank_wsel), .bank_wdata(bank_wdata), .bank_rsel(bank_rsel), .bank_rdata(bank_rdata)
   );

   logic [DW-1:0] bank [NREG];

   always @(posedge clk) begin
      for (int i = 0; i < NREG; i++)
         if (bank_wsel[i]) bank[i] <= bank_wdata;
   end

   always_comb begin
      bank_rdata = '0;
      for (int i = 0; i < NREG; i++)
         if (bank_rsel[i]) bank_rdata = bank_rdata | bank[i];
   end

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        rq;
      logic [3:0]  idx;
      logic        rl;
      logic        e_rdy;
      logic [8:0]  e_wsel;
      logic [8:0]  e_rsel;
      logic        e_full;
      logic [3:0]  e_wcnt;
      logic        e_rv;
      logic        e_re;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic rq,
                        input logic [3:0] idx, input logic rl);
      in_valid    = v;
      in_data     = d;
      rd_req      = rq;
      rd_idx      = idx;
      release_req = rl;
   endtask

   function automatic vec_t mk(logic v, logic [31:0] d, logic rq, logic [3:0] idx, logic rl,
                               logic e_rdy, logic [8:0] e_wsel, logic [8:0] e_rsel, logic e_full,
                               logic [3:0] e_wcnt, logic e_rv, logic e_re, logic [31:0] e_rd);
      vec_t r;
      r.v = v; r.d = d; r.rq = rq; r.idx = idx; r.rl = rl;
      r.e_rdy = e_rdy; r.e_wsel = e_wsel; r.e_rsel = e_rsel; r.e_full = e_full;
      r.e_wcnt = e_wcnt; r.e_rv = e_rv; r.e_re = e_re; r.e_rd = e_rd;
      return r;
   endfunction

   // Drive, check pre-edge outputs, clock, check registered read outputs.
   task automatic apply(input vec_t t, input string tag);
      drive(t.v, t.d, t.rq, t.idx, t.rl);
      #1;
      chk({tag, " in_ready"}, 32'(in_ready), 32'(t.e_rdy));
      chk({tag, " wsel"}, 32'(bank_wsel), 32'(t.e_wsel));
      chk({tag, " rsel"}, 32'(bank_rsel), 32'(t.e_rsel));
      chk({tag, " full"}, 32'(full), 32'(t.e_full));
      chk({tag, " wcnt"}, 32'(wcnt), 32'(t.e_wcnt));
      if (t.v && in_ready) chk({tag, " wdata"}, bank_wdata, t.d);
      @(posedge clk); #1;
      chk({tag, " rd_valid"}, 32'(rd_valid), 32'(t.e_rv));
      chk({tag, " rd_err"}, 32'(rd_err), 32'(t.e_re));
      chk({tag, " rd_data"}, rd_data, t.e_rd);
   endtask

   task automatic fill_gapped(input logic [31:0] base, input logic [31:0] rd_hold);
      for (int i = 0; i < NREG; i++) begin
         apply(mk(1, base + 32'(i), 0, 0, 0, 1, 9'(1 << i), 0, 0, 4'(i), 0, 0, rd_hold),
               $sformatf("gap_w%0d", i));
         if (i < NREG - 1)
            apply(mk(0, 32'hdead, 0, 0, 0, 1, 0, 0, 0, 4'(i + 1), 0, 0, rd_hold),
                  $sformatf("gap_g%0d", i));
      end
   endtask

   initial begin
      logic [31:0] last;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 1);
      chk("rst full", 32'(full), 0);
      chk("rst wcnt", 32'(wcnt), 0);
      chk("rst rd_valid", 32'(rd_valid), 0);
      chk("rst rd_err", 32'(rd_err), 0);
      chk("rst rd_data", rd_data, 0);
      chk("rst wsel", 32'(bank_wsel), 0);
      chk("rst rsel", 32'(bank_rsel), 0);
      reset = 1'b0;

      for (int i = 0; i < NREG; i++)
         vecs.push_back(mk(1, 32'h100 + 32'(i), 0, 0, 0, 1, 9'(1 << i), 0, 0, 4'(i), 0, 0, 0));
      vecs.push_back(mk(1, 32'h1ff, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8, 0, 0, 0, 9'h100, 1, 9, 1, 0, 32'h108));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 9'h001, 1, 9, 1, 0, 32'h100));
      vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 9'h010, 1, 9, 1, 0, 32'h104));
      vecs.push_back(mk(0, 0, 1, 9, 0, 0, 0, 0, 1, 9, 0, 1, 32'h104));
      vecs.push_back(mk(0, 0, 1, 3, 1, 0, 0, 9'h008, 1, 9, 1, 0, 32'h103));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h103));
      vecs.push_back(mk(0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 32'h103));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h103));
      vecs.push_back(mk(0, 0, 1, 15, 0, 1, 0, 0, 0, 0, 0, 1, 32'h103));

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Gapped refill, then read every entry back in order.
      fill_gapped(32'h200, 32'h103);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h103), "gap_full");
      for (int i = 0; i < NREG; i++)
         apply(mk(0, 0, 1, 4'(i), 0, 0, 0, 9'(1 << i), 1, 9, 1, 0, 32'h200 + 32'(i)),
               $sformatf("gap_rd%0d", i));
      apply(mk(0, 0, 1, 3, 1, 0, 0, 9'h008, 1, 9, 1, 0, 32'h203), "rel_rd3");

      // Partial fill of 5 words, then reset.
      for (int i = 0; i < 5; i++)
         apply(mk(1, 32'h300 + 32'(i), 0, 0, 0, 1, 9'(1 << i), 0, 0, 4'(i), 0, 0, 32'h203),
               $sformatf("part%0d", i));
      reset = 1'b1;
      drive(1, 32'h3ff, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      #1;
      chk("mid_rst wcnt", 32'(wcnt), 0);
      chk("mid_rst full", 32'(full), 0);
      chk("mid_rst in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;

      for (int i = 0; i < NREG; i++)
         apply(mk(1, 32'h400 + 32'(i), 0, 0, 0, 1, 9'(1 << i), 0, 0, 4'(i), 0, 0, 0),
               $sformatf("post_rst%0d", i));
      last = 32'h0;
      apply(mk(0, 0, 1, 5, 0, 0, 0, 9'h020, 1, 9, 1, 0, 32'h405), "post_rd5");
      apply(mk(0, 0, 1, 8, 0, 0, 0, 9'h100, 1, 9, 1, 0, 32'h408), "post_rd8");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h408), "post_idle");
      last = rd_data;
      chk("hold rd_data", last, 32'h408);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
